// File: rtl/set_associative_cache_controller.sv
// Set-associative write-back, write-allocate cache controller; hits respond 2 cycles after accept.
// Accepts one request at a time (ready only in IDLE); misses stall on the mem_ready_in handshake.
module set_associative_cache_controller #(
  parameter int cache_size        = 1024*8,
  parameter int cache_block       = 16*8,
  parameter int address_size      = 16,
  parameter int maximum_data_size = 64,
  parameter int no_of_ways        = 4,
  localparam int offset_size      = $clog2(cache_block/8),
  localparam int size_w           = $clog2(maximum_data_size)+1
) (
  input  logic                                  clock_in,
  input  logic                                  reset_n_in,
  input  logic                                  req_valid_in,
  output logic                                  req_ready_out,
  input  logic                                  write_in,
  input  logic [address_size-1:0]               address_in,
  input  logic [size_w-1:0]                     data_size_in,
  input  logic [maximum_data_size-1:0]          data_in,
  output logic                                  resp_valid_out,
  output logic                                  hit_out,
  output logic [maximum_data_size-1:0]          data_out,
  output logic                                  mem_read_out,
  output logic                                  mem_write_out,
  output logic [address_size-offset_size-1:0]   mem_address_out,
  output logic [cache_block-1:0]                mem_data_out,
  input  logic [cache_block-1:0]                mem_data_in,
  input  logic                                  mem_ready_in
);

  localparam int blk_bytes  = cache_block/8;
  localparam int max_bytes  = maximum_data_size/8;
  localparam int sets       = cache_size/cache_block/no_of_ways;
  localparam int index_size = $clog2(sets);
  localparam int tag_size   = address_size-index_size-offset_size;
  localparam int way_w      = $clog2(no_of_ways);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LOOKUP    = 3'd1;
  localparam logic [2:0] ST_WRITEBACK = 3'd2;
  localparam logic [2:0] ST_REFILL    = 3'd3;
  localparam logic [2:0] ST_RESPOND   = 3'd4;

  logic [2:0]                   state_q, state_d;
  logic                         ready_q, ready_d;
  logic                         req_write_q, req_write_d;
  logic [tag_size-1:0]          req_tag_q, req_tag_d;
  logic [index_size-1:0]        req_index_q, req_index_d;
  logic [offset_size-1:0]       req_offset_q, req_offset_d;
  logic [size_w-1:0]            req_size_q, req_size_d;
  logic [maximum_data_size-1:0] req_data_q, req_data_d;
  logic [way_w-1:0]             way_q, way_d;
  logic                         hit_q, hit_d;
  logic                         resp_vld_q, resp_vld_d;
  logic                         resp_hit_q, resp_hit_d;
  logic [maximum_data_size-1:0] resp_dat_q, resp_dat_d;

  logic [no_of_ways-1:0] valid_q [sets];
  logic [no_of_ways-1:0] valid_d [sets];
  logic [no_of_ways-1:0] dirty_q [sets];
  logic [no_of_ways-1:0] dirty_d [sets];
  logic [way_w-1:0]      age_q [sets][no_of_ways];
  logic [way_w-1:0]      age_d [sets][no_of_ways];
  logic [tag_size-1:0]   tag_q [sets][no_of_ways];
  logic [cache_block-1:0] blk_q [sets][no_of_ways];

  logic                   blk_we, tag_we;
  logic [cache_block-1:0] blk_wdat;

  logic                   lk_hit, vic_found;
  logic [way_w-1:0]       lk_way, vic_way;

  logic [cache_block-1:0]       cur_blk, shifted, st_blk;
  logic [maximum_data_size-1:0] ld_dat;
  logic                         sign_bit;
  int                           off_i, nb_i;

  always_comb begin
    lk_hit    = 1'b0;
    lk_way    = '0;
    vic_found = 1'b0;
    vic_way   = '0;
    for (int w = 0; w < no_of_ways; w++) begin
      if (!lk_hit && valid_q[req_index_q][w] && (tag_q[req_index_q][w] == req_tag_q)) begin
        lk_hit = 1'b1;
        lk_way = way_w'(w);
      end
    end
    for (int w = no_of_ways-1; w >= 0; w--) begin
      if (!valid_q[req_index_q][w]) begin
        vic_found = 1'b1;
        vic_way   = way_w'(w);
      end
    end
    // Ages form a permutation, so the oldest way always carries age no_of_ways-1.
    if (!vic_found) begin
      for (int w = 0; w < no_of_ways; w++) begin
        if (age_q[req_index_q][w] == way_w'(no_of_ways-1)) vic_way = way_w'(w);
      end
    end
  end

  always_comb begin
    cur_blk  = blk_q[req_index_q][way_q];
    off_i    = int'(req_offset_q);
    nb_i     = int'(req_size_q) / 8;
    shifted  = cur_blk >> (off_i*8);
    sign_bit = 1'b0;
    for (int i = 0; i < max_bytes; i++) begin
      if (i == nb_i-1) sign_bit = shifted[i*8+7];
    end
    ld_dat = '0;
    for (int i = 0; i < max_bytes; i++) begin
      ld_dat[i*8 +: 8] = (i < nb_i) ? shifted[i*8 +: 8] : {8{sign_bit}};
    end
    st_blk = cur_blk;
    for (int b = 0; b < blk_bytes; b++) begin
      if ((b >= off_i) && (b < off_i+nb_i)) st_blk[b*8 +: 8] = req_data_q[(b-off_i)*8 +: 8];
    end
  end

  always_comb begin
    state_d      = state_q;
    ready_d      = 1'b1;
    req_write_d  = req_write_q;
    req_tag_d    = req_tag_q;
    req_index_d  = req_index_q;
    req_offset_d = req_offset_q;
    req_size_d   = req_size_q;
    req_data_d   = req_data_q;
    way_d        = way_q;
    hit_d        = hit_q;
    resp_vld_d   = 1'b0;
    resp_hit_d   = 1'b0;
    resp_dat_d   = resp_dat_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    age_d        = age_q;
    blk_we       = 1'b0;
    tag_we       = 1'b0;
    blk_wdat     = mem_data_in;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_in && req_ready_out) begin
          req_write_d  = write_in;
          req_tag_d    = address_in[address_size-1 -: tag_size];
          req_index_d  = address_in[offset_size +: index_size];
          req_offset_d = address_in[offset_size-1:0];
          req_size_d   = data_size_in;
          req_data_d   = data_in;
          state_d      = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        hit_d = lk_hit;
        if (lk_hit) begin
          way_d   = lk_way;
          state_d = ST_RESPOND;
        end else begin
          way_d   = vic_way;
          state_d = (valid_q[req_index_q][vic_way] && dirty_q[req_index_q][vic_way])
                    ? ST_WRITEBACK : ST_REFILL;
        end
      end
      ST_WRITEBACK: begin
        if (mem_ready_in) state_d = ST_REFILL;
      end
      ST_REFILL: begin
        if (mem_ready_in) begin
          blk_we                        = 1'b1;
          tag_we                        = 1'b1;
          valid_d[req_index_q][way_q]   = 1'b1;
          dirty_d[req_index_q][way_q]   = 1'b0;
          state_d                       = ST_RESPOND;
        end
      end
      ST_RESPOND: begin
        resp_vld_d = 1'b1;
        resp_hit_d = hit_q;
        if (req_write_q) begin
          blk_we                      = 1'b1;
          blk_wdat                    = st_blk;
          dirty_d[req_index_q][way_q] = 1'b1;
          resp_dat_d                  = '0;
        end else begin
          resp_dat_d = ld_dat;
        end
        for (int w = 0; w < no_of_ways; w++) begin
          if (way_w'(w) == way_q) begin
            age_d[req_index_q][w] = '0;
          end else if (age_q[req_index_q][w] < age_q[req_index_q][way_q]) begin
            age_d[req_index_q][w] = age_q[req_index_q][w] + 1'b1;
          end
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q      <= ST_IDLE;
      ready_q      <= 1'b0;
      req_write_q  <= 1'b0;
      req_tag_q    <= '0;
      req_index_q  <= '0;
      req_offset_q <= '0;
      req_size_q   <= '0;
      req_data_q   <= '0;
      way_q        <= '0;
      hit_q        <= 1'b0;
      resp_vld_q   <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_dat_q   <= '0;
      for (int s = 0; s < sets; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < no_of_ways; w++) age_q[s][w] <= way_w'(w);
      end
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      req_write_q  <= req_write_d;
      req_tag_q    <= req_tag_d;
      req_index_q  <= req_index_d;
      req_offset_q <= req_offset_d;
      req_size_q   <= req_size_d;
      req_data_q   <= req_data_d;
      way_q        <= way_d;
      hit_q        <= hit_d;
      resp_vld_q   <= resp_vld_d;
      resp_hit_q   <= resp_hit_d;
      resp_dat_q   <= resp_dat_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      age_q        <= age_d;
    end
  end

  // Tag and data arrays carry no reset; the valid bits qualify them.
  always_ff @(posedge clock_in) begin
    if (blk_we) blk_q[req_index_q][way_q] <= blk_wdat;
    if (tag_we) tag_q[req_index_q][way_q] <= req_tag_q;
  end

  always_comb begin
    req_ready_out   = ready_q && (state_q == ST_IDLE);
    resp_valid_out  = resp_vld_q;
    hit_out         = resp_hit_q;
    data_out        = resp_dat_q;
    mem_write_out   = (state_q == ST_WRITEBACK);
    mem_read_out    = (state_q == ST_REFILL);
    mem_address_out = '0;
    mem_data_out    = '0;
    if (state_q == ST_WRITEBACK) begin
      mem_address_out = {tag_q[req_index_q][way_q], req_index_q};
      mem_data_out    = blk_q[req_index_q][way_q];
    end else if (state_q == ST_REFILL) begin
      mem_address_out = {req_tag_q, req_index_q};
    end
  end

endmodule

// File: tb/tb_set_associative_cache_controller.sv
// Scoreboard bench: a flat byte-memory plus per-set recency-list model predicts responses and memory traffic.
module tb_set_associative_cache_controller;

  logic         clock_in, reset_n_in;
  logic         req_valid_in, req_ready_out, write_in;
  logic [15:0]  address_in;
  logic [6:0]   data_size_in;
  logic [63:0]  data_in, data_out;
  logic         resp_valid_out, hit_out;
  logic         mem_read_out, mem_write_out, mem_ready_in;
  logic [11:0]  mem_address_out;
  logic [127:0] mem_data_out, mem_data_in;

  set_associative_cache_controller dut (
    .clock_in(clock_in), .reset_n_in(reset_n_in),
    .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
    .write_in(write_in), .address_in(address_in), .data_size_in(data_size_in), .data_in(data_in),
    .resp_valid_out(resp_valid_out), .hit_out(hit_out), .data_out(data_out),
    .mem_read_out(mem_read_out), .mem_write_out(mem_write_out), .mem_address_out(mem_address_out),
    .mem_data_out(mem_data_out), .mem_data_in(mem_data_in), .mem_ready_in(mem_ready_in)
  );

  typedef struct { bit wr; int addr; logic [127:0] dat; } mop_t;
  typedef struct { bit hit; logic [63:0] dat; int t0; } rsp_t;

  mop_t mexp[$];
  rsp_t rexp[$];
  int   nchecks = 0;
  int   nfail   = 0;
  int   cyc     = 0;
  int   mem_lat = 3;

  logic [7:0] arch [0:65535];
  logic [7:0] dram [0:65535];
  bit   m_valid [16][4];
  bit   m_dirty [16][4];
  int   m_tag   [16][4];
  int   rec     [16][$];

  initial begin
    clock_in = 1'b0;
    forever #5 clock_in = ~clock_in;
  end

  always @(posedge clock_in) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nchecks++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 16; s++) begin
      rec[s].delete();
      for (int w = 0; w < 4; w++) begin
        m_valid[s][w] = 0;
        m_dirty[s][w] = 0;
        rec[s].push_back(w);
      end
    end
    for (int i = 0; i < 65536; i++) arch[i] = dram[i];
  endtask

  task automatic model_access(input bit wr, input int addr, input int sz, input logic [63:0] dat, input int t0);
    int idx, tag, w, nb, pos, base;
    bit hit;
    mop_t m;
    rsp_t r;
    logic [63:0] v;
    idx = (addr >> 4) & 15;
    tag = addr >> 8;
    nb  = sz / 8;
    hit = 0;
    w   = -1;
    for (int i = 0; i < 4; i++)
      if (m_valid[idx][i] && m_tag[idx][i] == tag) begin hit = 1; w = i; end
    if (!hit) begin
      for (int i = 3; i >= 0; i--) if (!m_valid[idx][i]) w = i;
      if (w < 0) w = rec[idx][rec[idx].size()-1];
      if (m_valid[idx][w] && m_dirty[idx][w]) begin
        m.wr   = 1;
        m.addr = (m_tag[idx][w] << 4) | idx;
        base   = m.addr << 4;
        for (int b = 0; b < 16; b++) m.dat[b*8 +: 8] = arch[base+b];
        mexp.push_back(m);
      end
      m.wr   = 0;
      m.addr = (tag << 4) | idx;
      m.dat  = '0;
      mexp.push_back(m);
      m_valid[idx][w] = 1;
      m_tag[idx][w]   = tag;
      m_dirty[idx][w] = 0;
    end
    pos = 0;
    for (int i = 0; i < rec[idx].size(); i++) if (rec[idx][i] == w) pos = i;
    rec[idx].delete(pos);
    rec[idx].push_front(w);
    v = '0;
    if (wr) begin
      m_dirty[idx][w] = 1;
      for (int i = 0; i < nb; i++) arch[addr+i] = dat[i*8 +: 8];
      r.dat = '0;
    end else begin
      for (int i = 0; i < nb; i++) v[i*8 +: 8] = arch[addr+i];
      case (nb)
        1:       r.dat = {{56{v[7]}},  v[7:0]};
        2:       r.dat = {{48{v[15]}}, v[15:0]};
        4:       r.dat = {{32{v[31]}}, v[31:0]};
        default: r.dat = v;
      endcase
    end
    r.hit = hit;
    r.t0  = t0;
    rexp.push_back(r);
  endtask

  task automatic issue(input bit wr, input int addr, input int sz, input logic [63:0] dat);
    int g;
    g = 0;
    @(negedge clock_in);
    while (!req_ready_out && g < 300) begin
      @(negedge clock_in);
      g++;
    end
    if (!req_ready_out) begin
      chk("ready_timeout", req_ready_out, 1'b1);
      return;
    end
    req_valid_in = 1'b1;
    write_in     = wr;
    address_in   = 16'(addr);
    data_size_in = 7'(sz);
    data_in      = dat;
    model_access(wr, addr, sz, dat, cyc);
    @(negedge clock_in);
    req_valid_in = 1'b0;
  endtask

  // Memory responder: answers each strobe after mem_lat cycles unless reset or the strobe drops.
  initial begin
    int  k;
    bit  ok;
    int  base;
    mem_ready_in = 1'b0;
    mem_data_in  = '0;
    forever begin
      @(negedge clock_in);
      if (reset_n_in && (mem_read_out || mem_write_out)) begin
        k  = 1;
        ok = 1;
        while (k < mem_lat && ok) begin
          @(negedge clock_in);
          k++;
          ok = reset_n_in && (mem_read_out || mem_write_out);
        end
        if (ok) begin
          base = int'(mem_address_out) << 4;
          if (mem_write_out)
            for (int b = 0; b < 16; b++) dram[base+b] = mem_data_out[b*8 +: 8];
          for (int b = 0; b < 16; b++) mem_data_in[b*8 +: 8] = dram[base+b];
          mem_ready_in = 1'b1;
          @(negedge clock_in);
          mem_ready_in = 1'b0;
        end
      end
    end
  end

  bit   prev_r = 0;
  bit   prev_w = 0;
  mop_t mm;
  rsp_t rr;

  always @(negedge clock_in) begin
    if (!reset_n_in) begin
      prev_r = 0;
      prev_w = 0;
    end else begin
      if (mem_read_out || mem_write_out) chk("strobe_exclusive", mem_read_out & mem_write_out, 1'b0);
      if ((mem_write_out && !prev_w) || (mem_read_out && !prev_r)) begin
        if (mexp.size() == 0) begin
          chk("unexpected_mem_op", {mem_write_out, mem_read_out}, 2'b00);
        end else begin
          mm = mexp.pop_front();
          chk("mem_op_is_write", mem_write_out, mm.wr);
          chk("mem_address", mem_address_out, mm.addr);
          if (mm.wr) chk("writeback_data", mem_data_out, mm.dat);
        end
      end
      prev_r = mem_read_out;
      prev_w = mem_write_out;
      if (resp_valid_out) begin
        if (rexp.size() == 0) begin
          chk("unexpected_response", resp_valid_out, 1'b0);
        end else begin
          rr = rexp.pop_front();
          chk("hit_out", hit_out, rr.hit);
          chk("data_out", data_out, rr.dat);
          if (rr.hit) chk("hit_latency", cyc - rr.t0, 3);
        end
      end
    end
  end

  initial begin
    int g, tag, idx, nb, off;
    req_valid_in = 0; write_in = 0; address_in = '0; data_size_in = '0; data_in = '0;
    for (int i = 0; i < 65536; i++) dram[i] = 8'($urandom);
    model_reset();
    reset_n_in = 1'b1;
    #1 reset_n_in = 1'b0;
    #2;
    chk("rst_resp_valid", resp_valid_out, 1'b0);
    chk("rst_hit", hit_out, 1'b0);
    chk("rst_data", data_out, 64'h0);
    chk("rst_mem_read", mem_read_out, 1'b0);
    chk("rst_mem_write", mem_write_out, 1'b0);
    chk("rst_mem_addr", mem_address_out, 12'h0);
    chk("rst_mem_data", mem_data_out, 128'h0);
    repeat (3) @(negedge clock_in);
    reset_n_in = 1'b1;
    @(negedge clock_in);
    chk("ready_after_reset", req_ready_out, 1'b1);

    mem_lat = 3;
    issue(0, 16'h0040, 32, 64'h0);
    issue(0, 16'h0040, 32, 64'h0);
    issue(1, 16'h0043, 8, 64'hFF);
    issue(0, 16'h0043, 8, 64'h0);
    issue(0, 16'h0040, 32, 64'h0);
    issue(1, 16'h0150, 16, 64'h1234);
    issue(0, 16'h0250, 64, 64'h0);
    issue(0, 16'h0350, 8, 64'h0);
    issue(0, 16'h0450, 32, 64'h0);
    issue(0, 16'h0550, 16, 64'h0);
    issue(0, 16'h0150, 16, 64'h0);

    for (int n = 0; n < 200; n++) begin
      mem_lat = $urandom_range(1, 4);
      tag = $urandom_range(0, 5);
      idx = $urandom_range(0, 3);
      nb  = 1 << $urandom_range(0, 3);
      off = ($urandom_range(0, 15) / nb) * nb;
      issue($urandom_range(0, 1) == 1, (tag << 8) | (idx << 4) | off, nb*8, {$urandom, $urandom});
    end

    mem_lat = 4;
    issue(0, 16'h0F80, 32, 64'h0);
    g = 0;
    while (!mem_read_out && g < 20) begin
      @(negedge clock_in);
      g++;
    end
    chk("refill_seen_before_reset", mem_read_out, 1'b1);
    #2 reset_n_in = 1'b0;
    #1;
    chk("reset_drops_read", mem_read_out, 1'b0);
    chk("reset_drops_write", mem_write_out, 1'b0);
    chk("reset_no_resp", resp_valid_out, 1'b0);
    mexp.delete();
    rexp.delete();
    model_reset();
    repeat (3) @(negedge clock_in);
    reset_n_in = 1'b1;
    mem_lat = 2;
    issue(0, 16'h0F80, 32, 64'h0);
    issue(0, 16'h0F80, 32, 64'h0);

    g = 0;
    while ((mexp.size() != 0 || rexp.size() != 0) && g < 300) begin
      @(negedge clock_in);
      g++;
    end
    chk("scoreboard_drained", mexp.size() + rexp.size(), 0);
    repeat (2) @(negedge clock_in);
    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end

endmodule

// File: doc/set_associative_cache_controller.md
SET_ASSOCIATIVE_CACHE_CONTROLLER -- requirements
Module: set_associative_cache_controller

Interface
REQ-001 SHALL have parameter cache_size, default 1024*8, total data capacity in bits.
REQ-002 SHALL have parameter cache_block, default 16*8, block size in bits.
REQ-003 SHALL have parameter address_size, default 16, byte-address width.
REQ-004 SHALL have parameter maximum_data_size, default 64, widest access in bits; minimum_addressible_size fixed at 8.
REQ-005 SHALL have parameter no_of_ways, default 4, power of two >= 2; sets = cache_size/cache_block/no_of_ways, power of two >= 2.
REQ-006 clock_in  input  1  single clock, all state updates on rising edge.
REQ-007 reset_n_in  input  1  asynchronous, active-low reset.
REQ-008 req_valid_in  input  1  request present; req_ready_out  output  1  controller can accept.
REQ-009 write_in  input  1  1 = store, 0 = load; address_in  input  address_size  byte address.
REQ-010 data_size_in  input  log2(maximum_data_size)+1  access size in bits: 8, 16, 32 or 64.
REQ-011 data_in  input  maximum_data_size  store data, right-aligned.
REQ-012 resp_valid_out  output  1  one-cycle response pulse; hit_out  output  1  request hit; data_out  output  maximum_data_size  signed load result.
REQ-013 mem_read_out, mem_write_out  output  1  memory strobes; mem_address_out  output  address_size-offset_size  block address.
REQ-014 mem_data_out  output  cache_block  write-back data; mem_data_in  input  cache_block  refill data; mem_ready_in  input  1  memory completion pulse.

Function
REQ-015 Address split SHALL be tag | index | offset, offset = log2(cache_block/8), index = log2(sets).
REQ-016 Request SHALL be accepted only on a cycle where req_valid_in and req_ready_out are both 1; inputs captured then; req_ready_out 1 only in IDLE.
REQ-017 FSM states IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND; accept: IDLE->LOOKUP.
REQ-018 LOOKUP: hit = valid & tag match in any way; hit -> RESPOND; miss with dirty victim -> WRITEBACK; miss with clean/invalid victim -> REFILL.
REQ-019 Hit latency SHALL be exactly 2 cycles from accept edge to resp_valid_out high; RESPOND -> IDLE after one cycle.
REQ-020 Victim SHALL be lowest-index invalid way; if all valid, the way with maximum LRU age.
REQ-021 LRU: per-way age log2(no_of_ways) bits; on every completed access, accessed way age -> 0, ways with smaller age +1, others unchanged; ages always a permutation.
REQ-022 WRITEBACK: mem_write_out=1, mem_address_out={victim tag,index}, mem_data_out=victim block, held stable until mem_ready_in=1; then -> REFILL, strobe low next cycle.
REQ-023 REFILL: mem_read_out=1, mem_address_out={request tag,index}, held until mem_ready_in=1; block written from mem_data_in that edge, valid=1, dirty=0, -> RESPOND.
REQ-024 mem_read_out and mem_write_out SHALL never be 1 together; mem_ready_in outside WRITEBACK/REFILL ignored.
REQ-025 Load: data_out = bytes [offset, offset+size/8) little-endian, sign-extended to maximum_data_size; valid only when resp_valid_out=1, else holds last value.
REQ-026 Store: write-allocate, write-back; only addressed bytes updated, dirty=1; data_out=0 on store responses.
REQ-027 Offsets not aligned to access size: behaviour unspecified, bench shall not drive.
REQ-028 hit_out SHALL equal the LOOKUP hit result, valid with resp_valid_out.

Reset
REQ-029 reset_n_in low SHALL immediately clear all valid and dirty bits, set way w age = w, FSM -> IDLE.
REQ-030 During reset all outputs 0 except req_ready_out; req_ready_out=1 from first clock_in edge after reset_n_in high.
REQ-031 Reset mid-WRITEBACK/REFILL SHALL drop memory strobes asynchronously; in-flight request discarded, no response.

Verification
REQ-032 Cold load 0x0040 size 32 -> REFILL strobe, mem_address_out=0x004, mem_ready_in after 3 cycles, resp hit_out=0, data_out = sign-extended word.
REQ-033 Repeat load 0x0040 -> resp_valid_out exactly 2 cycles after accept, hit_out=1, no memory strobe.
REQ-034 Store 8'hFF to 0x0043 then load 8 bits 0x0043 -> data_out = -1 (all ones), hit_out=1; load 32 bits 0x0040 shows only byte 3 changed.
REQ-035 Fill one set with 5 distinct tags (4 ways), first dirty -> 5th access issues WRITEBACK of LRU way, then REFILL, in that order, never overlapping.
REQ-036 Assert reset_n_in low during REFILL -> strobes 0 same cycle, no resp_valid_out, subsequent load of same address misses.
